// File: rtl/ask_symbol_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ask_symbol_sequencer                                            |
// | Purpose  : Symbol-rate controller: DDS gating, FSK phase-increment select, |
// |            LFSR bit source, config applied only on symbol boundaries.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ask_symbol_sequencer #(
  parameter int unsigned           DIV_WIDTH         = 32,
  parameter logic [DIV_WIDTH-1:0]  DEFAULT_DIV       = 50_000_000,
  parameter logic [31:0]           DEFAULT_PHASE_INC = 258,
  parameter int unsigned           WARMUP_CYCLES     = 4,
  parameter logic [4:0]            LFSR_SEED         = 5'b00001
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [1:0]           cfg_mode,
  input  logic [31:0]          cfg_phase_inc0,
  input  logic [31:0]          cfg_phase_inc1,
  input  logic [DIV_WIDTH-1:0] cfg_divisor,
  output logic                 dds_en,
  output logic [31:0]          phase_inc,
  output logic                 modulator,
  output logic [1:0]           mode,
  output logic                 symbol_strobe,
  output logic [4:0]           lfsr_state,
  output logic                 busy
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_WARMUP   = 2'd1;
  localparam logic [1:0] c_RUN      = 2'd2;
  localparam logic [1:0] c_MODE_FSK = 2'b10;

  localparam int unsigned           c_WARM_W    = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [c_WARM_W-1:0]   c_WARM_LAST = c_WARM_W'(WARMUP_CYCLES - 1);

  logic [1:0]           r_state, w_state;
  logic [c_WARM_W-1:0]  r_warm_cnt, w_warm_cnt;
  logic [DIV_WIDTH-1:0] r_sym_cnt, w_sym_cnt;
  logic [4:0]           r_lfsr, w_lfsr;
  logic [1:0]           r_mode, w_mode, r_sh_mode, w_sh_mode;
  logic [31:0]          r_inc0, w_inc0, r_sh_inc0, w_sh_inc0;
  logic [31:0]          r_inc1, w_inc1, r_sh_inc1, w_sh_inc1;
  logic [DIV_WIDTH-1:0] r_div, w_div, r_sh_div, w_sh_div;
  logic                 r_pending, w_pending;
  logic                 r_stop_pending, w_stop_pending;

  logic                 r_dds_en, r_modulator, r_symbol_strobe, r_busy, r_cfg_ready;
  logic [31:0]          r_phase_inc;

  logic                 w_accept, w_term, w_run_next, w_mod_next;

  // A divisor of 0 behaves as 1: the terminal count is 0 either way.
  function automatic logic [DIV_WIDTH-1:0] f_last(input logic [DIV_WIDTH-1:0] d);
    return (d == '0) ? '0 : d - DIV_WIDTH'(1);
  endfunction

  assign w_accept = cfg_valid & r_cfg_ready;
  assign w_term   = (r_sym_cnt == f_last(r_div));

  always_comb begin
    w_state        = r_state;
    w_warm_cnt     = r_warm_cnt;
    w_sym_cnt      = r_sym_cnt;
    w_lfsr         = r_lfsr;
    w_mode         = r_mode;
    w_inc0         = r_inc0;
    w_inc1         = r_inc1;
    w_div          = r_div;
    w_sh_mode      = r_sh_mode;
    w_sh_inc0      = r_sh_inc0;
    w_sh_inc1      = r_sh_inc1;
    w_sh_div       = r_sh_div;
    w_pending      = r_pending;
    w_stop_pending = r_stop_pending;
    case (r_state)
      c_IDLE: begin
        if (w_accept) begin
          w_mode = cfg_mode;
          w_inc0 = cfg_phase_inc0;
          w_inc1 = cfg_phase_inc1;
          w_div  = cfg_divisor;
        end
        if (start && !stop) begin
          w_state    = c_WARMUP;
          w_lfsr     = LFSR_SEED;
          w_warm_cnt = '0;
          w_sym_cnt  = '0;
        end
      end
      c_WARMUP: begin
        // No symbol is in flight yet, so config may land directly.
        if (w_accept) begin
          w_mode = cfg_mode;
          w_inc0 = cfg_phase_inc0;
          w_inc1 = cfg_phase_inc1;
          w_div  = cfg_divisor;
        end
        if (stop) begin
          w_state = c_IDLE;
        end else if (r_warm_cnt == c_WARM_LAST) begin
          w_state   = c_RUN;
          w_sym_cnt = '0;
        end else begin
          w_warm_cnt = r_warm_cnt + c_WARM_W'(1);
        end
      end
      c_RUN: begin
        if (w_accept) begin
          w_sh_mode = cfg_mode;
          w_sh_inc0 = cfg_phase_inc0;
          w_sh_inc1 = cfg_phase_inc1;
          w_sh_div  = cfg_divisor;
          w_pending = 1'b1;
        end
        if (stop) w_stop_pending = 1'b1;
        if (w_term) begin
          w_sym_cnt = '0;
          if (r_pending) begin
            w_mode    = r_sh_mode;
            w_inc0    = r_sh_inc0;
            w_inc1    = r_sh_inc1;
            w_div     = r_sh_div;
            w_pending = 1'b0;
          end
          if (r_stop_pending || stop) begin
            w_state        = c_IDLE;
            w_stop_pending = 1'b0;
          end else begin
            w_lfsr = {r_lfsr[3:0], r_lfsr[4] ^ r_lfsr[2]};
          end
        end else begin
          w_sym_cnt = r_sym_cnt + DIV_WIDTH'(1);
        end
      end
      default: w_state = c_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they align with the state.
  assign w_run_next = (w_state == c_RUN);
  assign w_mod_next = w_run_next & w_lfsr[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= c_IDLE;
      r_warm_cnt      <= '0;
      r_sym_cnt       <= '0;
      r_lfsr          <= LFSR_SEED;
      r_mode          <= 2'b00;
      r_inc0          <= DEFAULT_PHASE_INC;
      r_inc1          <= DEFAULT_PHASE_INC;
      r_div           <= DEFAULT_DIV;
      r_sh_mode       <= 2'b00;
      r_sh_inc0       <= DEFAULT_PHASE_INC;
      r_sh_inc1       <= DEFAULT_PHASE_INC;
      r_sh_div        <= DEFAULT_DIV;
      r_pending       <= 1'b0;
      r_stop_pending  <= 1'b0;
      r_dds_en        <= 1'b0;
      r_modulator     <= 1'b0;
      r_phase_inc     <= DEFAULT_PHASE_INC;
      r_symbol_strobe <= 1'b0;
      r_busy          <= 1'b0;
      r_cfg_ready     <= 1'b1;
    end else begin
      r_state         <= w_state;
      r_warm_cnt      <= w_warm_cnt;
      r_sym_cnt       <= w_sym_cnt;
      r_lfsr          <= w_lfsr;
      r_mode          <= w_mode;
      r_inc0          <= w_inc0;
      r_inc1          <= w_inc1;
      r_div           <= w_div;
      r_sh_mode       <= w_sh_mode;
      r_sh_inc0       <= w_sh_inc0;
      r_sh_inc1       <= w_sh_inc1;
      r_sh_div        <= w_sh_div;
      r_pending       <= w_pending;
      r_stop_pending  <= w_stop_pending;
      r_dds_en        <= (w_state != c_IDLE);
      r_busy          <= (w_state != c_IDLE);
      r_modulator     <= w_mod_next;
      r_phase_inc     <= ((w_mode == c_MODE_FSK) && w_mod_next) ? w_inc1 : w_inc0;
      r_symbol_strobe <= w_run_next && (w_sym_cnt == f_last(w_div));
      r_cfg_ready     <= ~w_pending;
    end
  end

  assign cfg_ready     = r_cfg_ready;
  assign dds_en        = r_dds_en;
  assign phase_inc     = r_phase_inc;
  assign modulator     = r_modulator;
  assign mode          = r_mode;
  assign symbol_strobe = r_symbol_strobe;
  assign lfsr_state    = r_lfsr;
  assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ask_symbol_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_ask_symbol_sequencer                                         |
// | Purpose  : Directed self-checking bench for ask_symbol_sequencer.          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_ask_symbol_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_mode;
  logic [31:0] cfg_phase_inc0;
  logic [31:0] cfg_phase_inc1;
  logic [31:0] cfg_divisor;
  logic        dds_en;
  logic [31:0] phase_inc;
  logic        modulator;
  logic [1:0]  mode;
  logic        symbol_strobe;
  logic [4:0]  lfsr_state;
  logic        busy;

  int checks;
  int failures;

  // LFSR from seed 00001: 01, 02, 04, 09, 12, 05 -> low bits 1,0,0,1,0,1
  logic [31:0] mod_seq  [6] = '{32'd1, 32'd0, 32'd0, 32'd1, 32'd0, 32'd1};
  logic [31:0] lfsr_seq [6] = '{32'h01, 32'h02, 32'h04, 32'h09, 32'h12, 32'h05};
  logic [31:0] fsk_ph   [6] = '{32'd2000, 32'd1000, 32'd1000, 32'd2000, 32'd1000, 32'd2000};

  ask_symbol_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stop           (stop),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cfg_mode       (cfg_mode),
    .cfg_phase_inc0 (cfg_phase_inc0),
    .cfg_phase_inc1 (cfg_phase_inc1),
    .cfg_divisor    (cfg_divisor),
    .dds_en         (dds_en),
    .phase_inc      (phase_inc),
    .modulator      (modulator),
    .mode           (mode),
    .symbol_strobe  (symbol_strobe),
    .lfsr_state     (lfsr_state),
    .busy           (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_idle(input logic [1:0] m, input logic [31:0] i0, input logic [31:0] i1,
                          input logic [31:0] d);
    cfg_mode       = m;
    cfg_phase_inc0 = i0;
    cfg_phase_inc1 = i1;
    cfg_divisor    = d;
    cfg_valid      = 1'b1;
    tick(1);
    cfg_valid      = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    reset          = 1'b0;
    start          = 1'b0;
    stop           = 1'b0;
    cfg_valid      = 1'b0;
    cfg_mode       = 2'b00;
    cfg_phase_inc0 = 32'd0;
    cfg_phase_inc1 = 32'd0;
    cfg_divisor    = 32'd0;
    tick(3);
    reset = 1'b1;

    // Reset and idle outputs
    tick(20);
    chk("rst_dds_en", dds_en, 0);
    chk("rst_modulator", modulator, 0);
    chk("rst_strobe", symbol_strobe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_mode", mode, 0);
    chk("rst_phase_inc", phase_inc, 258);
    chk("rst_lfsr", lfsr_state, 1);

    // LFSR sequence with divisor 3
    cfg_idle(2'b00, 32'd500, 32'd600, 32'd3);
    chk("idle_cfg_phase_inc", phase_inc, 500);
    start_run();                       // now cycle 1
    chk("c1_dds_en", dds_en, 1);
    chk("c1_busy", busy, 1);
    chk("c1_modulator", modulator, 0);
    tick(3);                           // cycle 4, last warmup cycle
    chk("c4_modulator", modulator, 0);
    chk("c4_strobe", symbol_strobe, 0);
    tick(1);                           // cycle 5, first symbol
    for (int c = 0; c < 18; c++) begin
      chk($sformatf("lfsr_strobe_c%0d", c + 5), symbol_strobe, ((c % 3) == 2) ? 32'd1 : 32'd0);
      chk($sformatf("lfsr_mod_c%0d", c + 5), modulator, mod_seq[c / 3]);
      chk($sformatf("lfsr_val_c%0d", c + 5), lfsr_state, lfsr_seq[c / 3]);
      tick(1);
    end
    tick(74);                          // cycle 97, symbol 30
    chk("lfsr_sym30", lfsr_state, 32'h10);
    tick(1);                           // cycle 98, symbol 31 wraps to seed
    chk("lfsr_wrap", lfsr_state, 32'h01);
    chk("lfsr_wrap_mod", modulator, 1);
    stop = 1'b1;
    tick(1);                           // cycle 99
    stop = 1'b0;
    tick(1);                           // cycle 100, final strobe
    chk("stop3_strobe", symbol_strobe, 1);
    chk("stop3_busy", busy, 1);
    tick(1);                           // cycle 101
    chk("stop3_busy_off", busy, 0);
    chk("stop3_dds_off", dds_en, 0);
    chk("stop3_mod_off", modulator, 0);
    chk("stop3_lfsr_frozen", lfsr_state, 32'h01);

    // FSK switching, divisor 2
    cfg_idle(2'b10, 32'd1000, 32'd2000, 32'd2);
    chk("fsk_idle_phase", phase_inc, 1000);
    chk("fsk_idle_mode", mode, 2);
    start_run();
    tick(4);                           // cycle 5
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("fsk_mod_c%0d", c + 5), modulator, mod_seq[c / 2]);
      chk($sformatf("fsk_phase_c%0d", c + 5), phase_inc, fsk_ph[c / 2]);
      tick(1);
    end
    stop = 1'b1;                       // cycle 17, count 0
    tick(1);
    stop = 1'b0;
    tick(1);                           // cycle 19
    chk("fsk_stop_busy", busy, 0);
    chk("fsk_stop_phase", phase_inc, 1000);

    // Mid-run config: divisor 4 -> 2 -> 3
    cfg_idle(2'b00, 32'd700, 32'd700, 32'd4);
    chk("mid_idle_phase", phase_inc, 700);
    start_run();
    tick(4);                           // cycle 5
    chk("mid_c5_mod", modulator, 1);
    tick(1);                           // cycle 6, count 1
    chk("mid_c6_ready", cfg_ready, 1);
    cfg_valid   = 1'b1;
    cfg_divisor = 32'd2;
    tick(1);                           // cycle 7
    cfg_divisor = 32'd3;
    chk("mid_c7_ready", cfg_ready, 0);
    chk("mid_c7_strobe", symbol_strobe, 0);
    tick(1);                           // cycle 8
    chk("mid_c8_ready", cfg_ready, 0);
    chk("mid_c8_strobe", symbol_strobe, 1);
    tick(1);                           // cycle 9
    chk("mid_c9_ready", cfg_ready, 1);
    chk("mid_c9_strobe", symbol_strobe, 0);
    chk("mid_c9_mod", modulator, 0);
    tick(1);                           // cycle 10
    cfg_valid = 1'b0;
    chk("mid_c10_ready", cfg_ready, 0);
    chk("mid_c10_strobe", symbol_strobe, 1);
    tick(1);                           // cycle 11
    chk("mid_c11_ready", cfg_ready, 1);
    chk("mid_c11_strobe", symbol_strobe, 0);
    tick(1);
    chk("mid_c12_strobe", symbol_strobe, 0);
    tick(1);
    chk("mid_c13_strobe", symbol_strobe, 1);
    tick(1);                           // cycle 14, count 0
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    tick(1);                           // cycle 16
    chk("mid_c16_strobe", symbol_strobe, 1);
    tick(1);                           // cycle 17
    chk("mid_c17_busy", busy, 0);
    chk("mid_c17_lfsr", lfsr_state, 32'h09);

    // Stop at count 1 of 4, with a start that must be ignored
    cfg_idle(2'b00, 32'd700, 32'd700, 32'd4);
    start_run();
    tick(5);                           // cycle 6, count 1
    stop  = 1'b1;
    start = 1'b1;
    tick(1);                           // cycle 7
    stop  = 1'b0;
    start = 1'b0;
    chk("stp_c7_busy", busy, 1);
    chk("stp_c7_strobe", symbol_strobe, 0);
    tick(1);
    chk("stp_c8_strobe", symbol_strobe, 1);
    chk("stp_c8_busy", busy, 1);
    tick(1);                           // cycle 9
    chk("stp_c9_busy", busy, 0);
    chk("stp_c9_dds", dds_en, 0);
    chk("stp_c9_mod", modulator, 0);
    chk("stp_c9_lfsr", lfsr_state, 32'h01);

    // start together with stop in IDLE
    start = 1'b1;
    stop  = 1'b1;
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
    chk("ss_busy", busy, 0);
    chk("ss_dds", dds_en, 0);
    tick(1);
    chk("ss_busy2", busy, 0);

    // Divisor 0, then asynchronous reset mid-run
    cfg_idle(2'b00, 32'd258, 32'd258, 32'd0);
    start_run();
    tick(4);                           // cycle 5
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("div0_strobe_c%0d", c + 5), symbol_strobe, 1);
      chk($sformatf("div0_mod_c%0d", c + 5), modulator, mod_seq[c]);
      tick(1);
    end
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_dds", dds_en, 0);
    chk("arst_strobe", symbol_strobe, 0);
    chk("arst_mod", modulator, 0);
    chk("arst_lfsr", lfsr_state, 1);
    chk("arst_phase", phase_inc, 258);
    chk("arst_ready", cfg_ready, 1);
    chk("arst_mode", mode, 0);
    #2;
    reset = 1'b1;
    tick(2);
    chk("post_rst_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ask_symbol_sequencer.md
# ask_symbol_sequencer

Symbol-rate controller for the DDS `waveform_gen` and the ASK/BPSK modulators. It gates the DDS enable and drives its 32-bit phase increment, with FSK switching between two increments. A 5-bit LFSR generates the pseudo-random modulating bit at a programmable symbol period. Configuration from the Nios/Qsys side is accepted through a valid/ready handshake and applied only on symbol boundaries, so no symbol is ever truncated.

## Interface
- `DIV_WIDTH`, 32: width of the symbol-period divisor.
- `DEFAULT_DIV`, 50_000_000: reset symbol period in clocks (1 Hz at 50 MHz).
- `DEFAULT_PHASE_INC`, 258: reset value of both phase increments (3 Hz at 50 MHz).
- `WARMUP_CYCLES`, 4: DDS settle cycles between start and the first symbol (≥1).
- `LFSR_SEED`, 5'b00001: non-zero LFSR reset/restart value.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins transmission; only meaningful in IDLE.
- `stop`  in  1  one-cycle pulse that requests the end of transmission.
- `cfg_valid`  in  1  configuration offer.
- `cfg_ready`  out  1  configuration can be accepted; transfer happens when valid and ready.
- `cfg_mode`  in  2  modulation mode: 00 ASK, 01 BPSK, 10 FSK, 11 treated as ASK.
- `cfg_phase_inc0`  in  32  phase increment for bit 0, and for every bit outside FSK.
- `cfg_phase_inc1`  in  32  FSK phase increment for bit 1.
- `cfg_divisor`  in  DIV_WIDTH  symbol period in clocks.
- `dds_en`  out  1  to `waveform_gen.en`.
- `phase_inc`  out  32  to `waveform_gen.phase_inc`.
- `modulator`  out  1  modulating bit to the ASK/BPSK blocks.
- `mode`  out  2  active mode.
- `symbol_strobe`  out  1  high on the last clock of each symbol.
- `lfsr_state`  out  5  current LFSR value, for debug.
- `busy`  out  1  high when not in IDLE.

## Operation
- FSM states are IDLE, WARMUP and RUN. All outputs are registered.
- Reset values:
  - state IDLE; `dds_en`, `modulator`, `symbol_strobe` and `busy` are 0.
  - `cfg_ready` is 1; `mode` is 00.
  - `phase_inc`, inc0 and inc1 equal `DEFAULT_PHASE_INC`; divisor equals `DEFAULT_DIV`.
  - `lfsr_state` equals `LFSR_SEED`.
- **IDLE:** `dds_en` is 0 and `modulator` is 0. An accepted config loads the active registers directly on that edge.
  - `start` reloads the LFSR with the seed, clears the counters and moves to WARMUP.
  - If `start` and `stop` arrive in the same cycle, `stop` wins and the FSM stays in IDLE.
- **WARMUP:** `dds_en` is 1 and `modulator` is held at 0. The FSM counts `WARMUP_CYCLES` clocks, then moves to RUN.
  - `stop` during WARMUP returns to IDLE on the next edge.
- **RUN:** `dds_en` is 1 and `modulator` equals `lfsr_state[0]`.
  - The symbol counter counts from 0 to divisor−1. At the terminal count `symbol_strobe` is 1.
  - On the following edge the LFSR advances, any pending config is applied, and the counter clears.
- **LFSR:** Fibonacci form, x^5+x^3+1, period 31. Next value is `{lfsr[3:0], lfsr[4]^lfsr[2]}`. It never reaches all-zero.
- **Phase increment:** in FSK, `phase_inc` = `modulator` ? inc1 : inc0. In every other mode it is inc0. It updates in the same cycle that `modulator` changes.
- **Config in RUN:** the transfer goes into a shadow register and `cfg_ready` drops to 0 while a config is pending.
  - The shadow is applied at the next symbol boundary after acceptance. If acceptance happens in the same cycle as the strobe, it applies at the following boundary.
  - `cfg_ready` returns to 1 the cycle after the shadow is applied.
- **Stop in RUN:** `stop` sets `stop_pending`. The current symbol completes, then the FSM goes to IDLE.
  - On that boundary the LFSR does not advance, but a pending config is still applied.
  - Further `stop` or `start` pulses while pending are ignored.
- **Divisor boundary:** a divisor of 0 is treated as 1, which produces a new symbol and a strobe every clock.
- **Reset mid-operation:** the FSM returns immediately to reset values. Any pending shadow config is discarded.

## Timing
- `start` sampled at edge 0 gives `busy`=1 and `dds_en`=1 from cycle 1.
- RUN begins at cycle 1+`WARMUP_CYCLES`. The first symbol's bit is `LFSR_SEED[0]`.
- Each symbol lasts exactly divisor clocks. `modulator` changes on the clock after `symbol_strobe`.
- Config accepted in IDLE is visible on the outputs one cycle later.
- After a graceful stop, `dds_en`, `busy` and `modulator` are 0 on the cycle after the final strobe.

## Test plan
- **Reset and idle outputs:** reset, then idle for 20 cycles → all outputs at reset values and `phase_inc`=258.
- **LFSR sequence:** divisor=3, `WARMUP_CYCLES`=4, start at cycle 0.
  - `dds_en`=1 at cycle 1; the first symbol starts at cycle 5.
  - Strobes occur at cycles 7, 10 and 13.
  - `modulator` sequence is 1,0,0,1,0,1 (LFSR 00001, 00010, 00100, 01001, 10010, 00101).
  - The LFSR returns to 00001 after 31 symbols.
- **FSK switching:** mode=10, inc0=1000, inc1=2000, divisor=2 → `phase_inc` tracks `modulator` with zero skew, starting at 2000 in the first symbol.
- **Mid-run config:** divisor changed from 4 to 2 in the middle of a symbol.
  - `cfg_ready` is 0 until the boundary.
  - The current symbol still lasts 4 clocks; subsequent symbols last 2.
  - A second `cfg_valid` held high is accepted only once `cfg_ready` returns.
- **Stop handling:** `stop` at symbol count 1 of 4 → three more clocks in RUN, then IDLE with the LFSR frozen. `start` together with `stop` in IDLE → no transition.
- **Divisor 0 and async reset:** divisor=0 → `symbol_strobe` high on every RUN clock. Asserting `reset` low mid-RUN → outputs reach reset values without waiting for a clock edge.
